cva6_rvfi_serializer: RTL

Scheduler that shares a single trace output channel between the NrCommitPorts RVFI retirement ports.
- Each cycle it captures all valid rvfi_instr_t entries into a multi-push, single-pop FIFO, in port order.
- It drains them one per handshake to a downstream trace consumer (DPI tracer or trace encoder).
- Each entry is tagged with a monotonically increasing retirement order number.
- It reports backpressure and lost entries, since the RVFI side cannot be stalled.

---
 rtl/config_pkg.sv | 10 +
 rtl/cva6_rvfi_pkg.sv | 21 ++
 rtl/cva6_rvfi_mpfifo.sv | 58 +++++
 rtl/cva6_rvfi_serializer.sv | 92 +++++++++
 4 files changed

// File: rtl/config_pkg.sv
// config_pkg: minimal core configuration record carrying the commit-port count.
package config_pkg;

    typedef struct packed {
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2};

endpackage

// File: rtl/cva6_rvfi_pkg.sv
// cva6_rvfi_pkg: shared RVFI trace types and constants.
package cva6_rvfi_pkg;

    localparam int unsigned RVFI_DROP_CNT_W = 16;
    localparam int unsigned RVFI_ORDER_W    = 64;

    typedef logic [RVFI_ORDER_W-1:0] rvfi_order_t;

    // Default retirement record; any type with a valid field may be substituted.
    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [63:0] pc_rdata;
    } rvfi_rec_t;

    typedef struct packed {
        rvfi_rec_t   instr;
        rvfi_order_t order;
    } rvfi_trace_entry_t;

endpackage

// File: rtl/cva6_rvfi_mpfifo.sv
// cva6_rvfi_mpfifo: NPUSH-wide compacting push, single-pop FIFO.
module cva6_rvfi_mpfifo #(
    parameter int unsigned NPUSH = 2,
    parameter int unsigned DEPTH = 8,
    parameter type data_t = logic,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NPUSH-1:0] push_valid,
    input  data_t            push_data [NPUSH],
    input  logic             pop_i,
    output logic [CW-1:0]    free_o,
    output logic [CW-1:0]    count_o,
    output data_t            head_o,
    output logic             empty_o
);

    data_t         mem_q [DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] cnt_q, n_push;
    logic [AW-1:0] slot [NPUSH];
    logic          pop;

    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign pop     = pop_i && !empty_o;
    assign free_o  = CW'(DEPTH) - cnt_q + CW'(pop);
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    // Valid lanes land in consecutive slots regardless of holes in push_valid.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NPUSH; i++) begin
            slot[i] = wptr_q + n_push[AW-1:0];
            n_push  = n_push + CW'(push_valid[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NPUSH; i++)
            if (push_valid[i]) mem_q[slot[i]] <= push_data[i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_q + AW'(pop);
            wptr_q <= wptr_q + n_push[AW-1:0];
            cnt_q  <= cnt_q + n_push - CW'(pop);
        end
    end

endmodule

// File: rtl/cva6_rvfi_serializer.sv
// cva6_rvfi_serializer: funnels the RVFI commit ports into one ordered trace stream,
// counting entries lost when the buffer cannot absorb a retirement burst.
module cva6_rvfi_serializer
    import cva6_rvfi_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type rvfi_instr_t = rvfi_rec_t,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ORDER_W = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  rvfi_instr_t                rvfi_instr_i [CVA6Cfg.NrCommitPorts],
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output rvfi_instr_t                trace_instr_o,
    output logic [ORDER_W-1:0]         trace_order_o,
    output logic                       almost_full_o,
    output logic                       overflow_o,
    input  logic                       clear_overflow_i,
    output logic [RVFI_DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned NP = CVA6Cfg.NrCommitPorts;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = RVFI_DROP_CNT_W + 1;

    typedef struct packed {
        rvfi_instr_t        instr;
        logic [ORDER_W-1:0] order;
    } entry_t;

    logic [ORDER_W-1:0]         order_q;
    logic [CW-1:0]              free, count, n_valid, accepted;
    logic [NP-1:0]              push_valid;
    entry_t                     push_data [NP];
    entry_t                     head;
    logic                       empty;
    logic [RVFI_DROP_CNT_W-1:0] drop_base;
    logic [DW-1:0]              drop_sum;

    // A lane is accepted while its rank among valid lanes still fits in post-pop free space.
    always_comb begin
        n_valid  = '0;
        accepted = '0;
        for (int i = 0; i < NP; i++) begin
            push_valid[i]         = enable_i && rvfi_instr_i[i].valid && (n_valid < free);
            push_data[i].instr    = rvfi_instr_i[i];
            push_data[i].order    = order_q + ORDER_W'(n_valid);
            n_valid               = n_valid + CW'(enable_i && rvfi_instr_i[i].valid);
            accepted              = accepted + CW'(push_valid[i]);
        end
    end

    assign drop_base = clear_overflow_i ? '0 : drop_cnt_o;
    assign drop_sum  = {1'b0, drop_base} + DW'(n_valid - accepted);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            order_q    <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            order_q    <= order_q + ORDER_W'(accepted);
            overflow_o <= (overflow_o && !clear_overflow_i) || (n_valid != accepted);
            drop_cnt_o <= drop_sum[DW-1] ? '1 : drop_sum[DW-2:0];
        end
    end

    cva6_rvfi_mpfifo #(
        .NPUSH (NP),
        .DEPTH (DEPTH),
        .data_t(entry_t)
    ) i_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_valid(push_valid),
        .push_data (push_data),
        .pop_i     (trace_ready_i),
        .free_o    (free),
        .count_o   (count),
        .head_o    (head),
        .empty_o   (empty)
    );

    assign trace_valid_o = !empty;
    assign trace_instr_o = head.instr;
    assign trace_order_o = head.order;
    assign almost_full_o = count >= CW'(DEPTH - NP);

endmodule
